// File: rtl/tt_um_seven_segment_reader.sv
// Seven-segment bus reader: glitch filter, BCD decode, 0..9 sequence check, digit-change period.
// Define SEG_READER_SEQ_CHECK_EN to build the sticky sequence-error flag on uo_out[5].
module tt_um_seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {SEARCH, LOCKED, TRACKING} state_t;

  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [6:0]  samp;
  logic [7:0]  stab;
  logic [3:0]  digit;
  logic [23:0] cnt;
  logic [23:0] cnt_inc;
  logic [23:0] period_reg;
  logic        pulse;
  logic        dot;
  logic        err;
  logic        same;
  logic        accept;
  logic        lock;
  logic        change;
  logic [4:0]  dec;
  logic        unused_ok;

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = {1'b1, 4'd0};
      7'h06:   seg_decode = {1'b1, 4'd1};
      7'h5B:   seg_decode = {1'b1, 4'd2};
      7'h4F:   seg_decode = {1'b1, 4'd3};
      7'h66:   seg_decode = {1'b1, 4'd4};
      7'h6D:   seg_decode = {1'b1, 4'd5};
      7'h7D:   seg_decode = {1'b1, 4'd6};
      7'h07:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h6F:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  assign unused_ok = &{1'b0, ena, uio_in};

  // Accept fires on the edge where stab would reach STABLE_CYCLES; samp already equals the input.
  assign same    = (ui_in[6:0] == samp);
  assign accept  = same && (stab == STAB_LAST);
  assign dec     = seg_decode(samp);
  assign cnt_inc = (cnt == 24'hFFFFFF) ? cnt : cnt + 24'd1;

  always_comb begin
    state_d = state_q;
    lock    = 1'b0;
    change  = 1'b0;
    if (accept) begin
      if (!dec[4]) begin
        state_d = SEARCH;
      end else if (state_q == SEARCH) begin
        lock    = 1'b1;
        state_d = LOCKED;
      end else if (dec[3:0] != digit) begin
        change  = 1'b1;
        state_d = TRACKING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp       <= 7'h00;
      stab       <= 8'd0;
      digit      <= 4'd0;
      cnt        <= 24'd0;
      period_reg <= 24'd0;
      pulse      <= 1'b0;
      dot        <= 1'b0;
    end else begin
      if (!same) begin
        samp <= ui_in[6:0];
        stab <= 8'd0;
      end else if (stab != STAB_MAX) begin
        stab <= stab + 8'd1;
      end
      if (lock || change) digit <= dec[3:0];
      pulse <= lock || change;
      // Record edges since the previous change, counting this one.
      if (change && state_q == TRACKING) period_reg <= cnt_inc;
      cnt <= change ? 24'd0 : cnt_inc;
      dot <= change ? ui_in[7] : (dot | ui_in[7]);
    end
  end

`ifdef SEG_READER_SEQ_CHECK_EN
  logic [3:0] digit_next;
  assign digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n)                              err <= 1'b0;
    else if (change && dec[3:0] != digit_next) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign uo_out  = {dot, pulse, err, (state_q != SEARCH), digit};
  assign uio_out = period_reg[23:16];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_seven_segment_reader.sv
// Scoreboard bench: expected {uio_out, uo_out} queued per accepted digit, popped on each change pulse.
module tb_tt_um_seven_segment_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'hA5;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

`ifdef SEG_READER_SEQ_CHECK_EN
  localparam logic [7:0] ERRB = 8'h20;
`else
  localparam logic [7:0] ERRB = 8'h00;
`endif

  tt_um_seven_segment_reader #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive p for n edges; returns 1 time unit after the last edge.
  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      ui_in = p;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold(8'hC3, 2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && uo_out[6] === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", {24'd0, uo_out}, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("accept", {16'd0, uio_out, uo_out}, {16'd0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();
    chk("rst_uo",  {24'd0, uo_out},  32'h00);
    chk("rst_uio", {24'd0, uio_out}, 32'h00);
    chk("rst_oe",  {24'd0, uio_oe},  32'hFF);

    // Four samples are one short of acceptance.
    hold(8'h3F, 4);
    chk("short_run_valid", {31'd0, uo_out[4]}, 32'd0);
    exp_q.push_back({8'h00, 8'h50});
    hold(8'h3F, 1);
    chk("first_accept", {24'd0, uo_out}, 32'h50);
    hold(8'h3F, 1);
    chk("pulse_one_cycle", {24'd0, uo_out}, 32'h10);

    // Glitch of 4 samples, then return to the held digit.
    hold(8'h06, 4);
    hold(8'h3F, 6);
    chk("glitch_hold", {24'd0, uo_out}, 32'h10);

    // Skip from 0 to 2, then a correct 3: error is sticky.
    exp_q.push_back({8'h00, 8'h52 | ERRB});
    hold(8'h5B, 5);
    exp_q.push_back({8'h00, 8'h53 | ERRB});
    hold(8'h4F, 6);
    chk("seq_err_sticky", {31'd0, uo_out[5]}, {31'd0, ERRB[5]});

    do_reset();
    chk("rst2_uo", {24'd0, uo_out}, 32'h00);

    // Period: accept 2 exactly 65536 edges after accepting 1.
    exp_q.push_back({8'h00, 8'h50});
    hold(8'h3F, 5);
    exp_q.push_back({8'h00, 8'h51});
    hold(8'h06, 5);
    hold(8'h06, 65531);
    hold(8'h5B, 4);
    chk("period_before", {24'd0, uio_out}, 32'h00);
    exp_q.push_back({8'h01, 8'h52});
    hold(8'h5B, 1);
    chk("period_uio", {24'd0, uio_out}, 32'h01);
    chk("period_uo",  {24'd0, uo_out},  32'h52);

    // Invalid pattern drops valid, digit and period hold.
    hold(8'h00, 5);
    chk("invalid_uo",  {24'd0, uo_out},  32'h02);
    chk("invalid_uio", {24'd0, uio_out}, 32'h01);

    // Relock on 1 with the decimal point lit.
    exp_q.push_back({8'h01, 8'hD1});
    hold(8'h86, 5);
    chk("dot_uo",  {24'd0, uo_out},  32'hD1);
    hold(8'h86, 1);
    chk("dot_uio", {24'd0, uio_out}, 32'h01);

    // A change-accept without dot clears dot seen.
    exp_q.push_back({8'h01, 8'h52});
    hold(8'h5B, 5);
    hold(8'h5B, 2);
    chk("dot_cleared", {24'd0, uo_out}, 32'h12);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
